// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered instruction-decode stage between fetch and the immediate decoder /
// execute path. The opcode is classified on the input side, so the output
// registers hold the decoded fields (format code, register indices, flags).
// The only raw field kept is the immediate slice instr[31:OPCODE_LEN]. The
// downstream immediate decoder sign-extends that slice combinationally.
//
// Optional feature macro: DECODE_SKID_EN
//   undefined : single entry. in_ready = rst_n && (!out_valid || out_ready).
//   defined   : output entry plus one skid entry. in_ready = rst_n && !skid_valid.
//               This build has no combinational path from out_ready to in_ready.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      fetch offers an instruction
//   in_ready      stage can accept
//   in_instr      32-bit instruction word
//   in_pc         PC of in_instr
//   flush         drop everything held and anything offered this cycle
//   out_valid     decoded instruction available
//   out_ready     consumer accepts
//   out_pc        registered PC
//   out_imm       instr[31:OPCODE_LEN]
//   out_imm_ctrl  immediate format code (I/S/B/U/J)
//   out_has_imm   0 for R-type and for illegal opcodes
//   out_rd/rs1/rs2 register indices
//   out_funct3    instr[14:12]
//   out_illegal   opcode not recognised
//   out_count     delivered-instruction counter (wraps, survives flush)
// -----------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif
`ifndef OPCODE_LEN
`define OPCODE_LEN 7
`endif
`ifndef MAX_IMM_LEN
`define MAX_IMM_LEN (32 - `OPCODE_LEN)
`endif
`ifndef I_TYPE
`define I_TYPE 3'b000
`endif
`ifndef S_TYPE
`define S_TYPE 3'b001
`endif
`ifndef B_TYPE
`define B_TYPE 3'b010
`endif
`ifndef U_TYPE
`define U_TYPE 3'b011
`endif
`ifndef J_TYPE
`define J_TYPE 3'b100
`endif

module decode_stage (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [`XLEN-1:0]         in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [`XLEN-1:0]         out_pc,
    output logic [`MAX_IMM_LEN-1:0]  out_imm,
    output logic [2:0]               out_imm_ctrl,
    output logic                     out_has_imm,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [2:0]               out_funct3,
    output logic                     out_illegal,
    output logic [31:0]              out_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // One decoded entry, as held in the output (and skid) register.
    typedef struct packed {
        logic [`XLEN-1:0]        pc;
        logic [`MAX_IMM_LEN-1:0] imm;
        logic [2:0]              imm_ctrl;
        logic                    has_imm;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [2:0]              funct3;
        logic                    illegal;
    } dec_t;

    // -------------------------------------------------------------------------
    // Input-side decode
    // -------------------------------------------------------------------------
    logic [6:0] w_opcode;
    dec_t       w_dec;
    dec_t       w_rst_dec;

    assign w_opcode = in_instr[`OPCODE_LEN-1:0];

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = in_pc;
        w_dec.imm      = in_instr[31:`OPCODE_LEN];
        w_dec.rd       = in_instr[11:7];
        w_dec.rs1      = in_instr[19:15];
        w_dec.rs2      = in_instr[24:20];
        w_dec.funct3   = in_instr[14:12];
        w_dec.imm_ctrl = `I_TYPE;
        w_dec.has_imm  = 1'b1;
        w_dec.illegal  = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC:           w_dec.imm_ctrl = `U_TYPE;
            OP_JAL:                     w_dec.imm_ctrl = `J_TYPE;
            OP_JALR, OP_LOAD, OP_OPIMM: w_dec.imm_ctrl = `I_TYPE;
            OP_BRANCH:                  w_dec.imm_ctrl = `B_TYPE;
            OP_STORE:                   w_dec.imm_ctrl = `S_TYPE;
            OP_OP:                      w_dec.has_imm  = 1'b0;
            default: begin
                // Unknown opcodes still travel down the pipe, flagged.
                w_dec.has_imm = 1'b0;
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Reset image of an entry: all zero except the format code.
    always_comb begin
        w_rst_dec          = '0;
        w_rst_dec.imm_ctrl = `I_TYPE;
    end

    // -------------------------------------------------------------------------
    // Handshake and storage
    // -------------------------------------------------------------------------
    dec_t        r_out;
    logic        r_out_valid;
    logic [31:0] r_count;
    logic        w_in_xfer;
    logic        w_out_xfer;

    assign w_out_xfer = r_out_valid && out_ready;
    assign w_in_xfer  = in_valid && in_ready && !flush;

`ifdef DECODE_SKID_EN
    dec_t r_skid;
    logic r_skid_valid;

    // Ready depends only on registered state (and reset), never on out_ready.
    assign in_ready = rst_n && !r_skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out        <= w_rst_dec;
            r_skid       <= w_rst_dec;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_count      <= 32'd0;
        end else begin
            // A delivery in the flush cycle still counts.
            if (w_out_xfer) begin
                r_count <= r_count + 32'd1;
            end
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_out_valid || out_ready) begin
                // The output slot frees up this cycle. Refill it from the skid
                // entry first so that order is preserved.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_xfer) begin
                // The output is stalled, so park one more entry in the skid slot.
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end
`else
    assign in_ready = rst_n && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= w_rst_dec;
            r_out_valid <= 1'b0;
            r_count     <= 32'd0;
        end else begin
            if (w_out_xfer) begin
                r_count <= r_count + 32'd1;
            end
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid    = r_out_valid;
    assign out_pc       = r_out.pc;
    assign out_imm      = r_out.imm;
    assign out_imm_ctrl = r_out.imm_ctrl;
    assign out_has_imm  = r_out.has_imm;
    assign out_rd       = r_out.rd;
    assign out_rs1      = r_out.rs1;
    assign out_rs2      = r_out.rs2;
    assign out_funct3   = r_out.funct3;
    assign out_illegal  = r_out.illegal;
    assign out_count    = r_count;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef OPCODE_LEN
`define OPCODE_LEN 7
`endif
`ifndef MAX_IMM_LEN
`define MAX_IMM_LEN (32 - `OPCODE_LEN)
`endif
`ifndef I_TYPE
`define I_TYPE 3'b000
`endif
`ifndef S_TYPE
`define S_TYPE 3'b001
`endif
`ifndef B_TYPE
`define B_TYPE 3'b010
`endif
`ifndef U_TYPE
`define U_TYPE 3'b011
`endif
`ifndef J_TYPE
`define J_TYPE 3'b100
`endif

module tb_decode_stage;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_instr;
    logic [`XLEN-1:0]        in_pc;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [`XLEN-1:0]        out_pc;
    logic [`MAX_IMM_LEN-1:0] out_imm;
    logic [2:0]              out_imm_ctrl;
    logic                    out_has_imm;
    logic [4:0]              out_rd;
    logic [4:0]              out_rs1;
    logic [4:0]              out_rs2;
    logic [2:0]              out_funct3;
    logic                    out_illegal;
    logic [31:0]             out_count;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_imm_ctrl(out_imm_ctrl),
        .out_has_imm (out_has_imm),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_illegal (out_illegal),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [`XLEN-1:0]        pc;
        logic [`MAX_IMM_LEN-1:0] imm;
        logic [2:0]              ctrl;
        logic                    has_imm;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [2:0]              f3;
        logic                    ill;
    } item_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    item_t       sb_q[$];
    logic [31:0] m_count = 32'd0;
    logic [31:0] pc_ctr = 32'h0000_1000;

`ifdef DECODE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic item_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        item_t it;
        logic [6:0] op;
        op = ins[6:0];
        it.pc = pc;
        it.imm = ins >> 7;
        it.rd = ins[11:7];
        it.rs1 = ins[19:15];
        it.rs2 = ins[24:20];
        it.f3 = ins[14:12];
        it.ctrl = `I_TYPE;
        it.has_imm = 1'b1;
        it.ill = 1'b0;
        if (op == 7'h37 || op == 7'h17) it.ctrl = `U_TYPE;
        else if (op == 7'h6F) it.ctrl = `J_TYPE;
        else if (op == 7'h67 || op == 7'h03 || op == 7'h13) it.ctrl = `I_TYPE;
        else if (op == 7'h63) it.ctrl = `B_TYPE;
        else if (op == 7'h23) it.ctrl = `S_TYPE;
        else if (op == 7'h33) it.has_imm = 1'b0;
        else begin
            it.has_imm = 1'b0;
            it.ill = 1'b1;
        end
        return it;
    endfunction

    // Monitor / scoreboard: samples mid-cycle, checks, then applies the
    // handshakes that will take effect at the coming edge.
    initial begin
        item_t act;
        item_t dummy;
        logic  exp_rdy;
        forever begin
            @(negedge clk);
            if (DEPTH == 2) exp_rdy = rst_n && (sb_q.size() < 2);
            else            exp_rdy = rst_n && (sb_q.size() == 0 || out_ready);
            chk("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
            chk("out_valid", {127'd0, out_valid}, {127'd0, (sb_q.size() != 0)});
            chk("out_count", {96'd0, out_count}, {96'd0, m_count});
            if (out_valid && sb_q.size() != 0) begin
                act = '{out_pc, out_imm, out_imm_ctrl, out_has_imm, out_rd,
                        out_rs1, out_rs2, out_funct3, out_illegal};
                chk("payload", {48'd0, act}, {48'd0, sb_q[0]});
            end
            if (!rst_n) begin
                sb_q.delete();
                m_count = 32'd0;
            end else begin
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    dummy = sb_q.pop_front();
                    m_count = m_count + 32'd1;
                    $display("deliver pc=%08h ctrl=%0d ill=%0b count=%0d",
                             dummy.pc, dummy.ctrl, dummy.ill, m_count);
                end
                if (flush) sb_q.delete();
                else if (in_valid && in_ready) sb_q.push_back(ref_decode(in_instr, in_pc));
            end
        end
    end

    // Called at posedge+1: drives one cycle, reports whether it was accepted.
    task automatic offer(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic fl, output logic acc);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc_ctr;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        acc = in_valid && in_ready && !flush;
        @(posedge clk);
        #1;
        if (acc) pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready_low", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_count", {96'd0, out_count}, 128'd0);
        chk("rst_in_ready_after", {127'd0, in_ready}, 128'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h7F};
        r = $urandom();
        if ($urandom_range(0, 9) == 0) return r;
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        logic        acc;
        logic [31:0] pend[$];
        logic [31:0] sweep [10];
        logic [31:0] lui_w;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_out_pc", {96'd0, out_pc}, 128'd0);
        chk("reset_out_imm", {103'd0, out_imm}, 128'd0);
        chk("reset_imm_ctrl", {125'd0, out_imm_ctrl}, {125'd0, `I_TYPE});
        chk("reset_out_count", {96'd0, out_count}, 128'd0);
        @(posedge clk);
        #1;

        // Single transfers: LUI held, then BEQ
        lui_w = 32'h123450B7;
        offer(1'b1, lui_w, 1'b0, 1'b0, acc);
        chk("lui_ctrl", {125'd0, out_imm_ctrl}, {125'd0, `U_TYPE});
        chk("lui_has_imm", {127'd0, out_has_imm}, 128'd1);
        chk("lui_rd", {123'd0, out_rd}, 128'd1);
        chk("lui_imm", {103'd0, out_imm}, {96'd0, lui_w >> 7});
        offer(1'b1, 32'h00C58663, 1'b1, 1'b0, acc);
        chk("beq_ctrl", {125'd0, out_imm_ctrl}, {125'd0, `B_TYPE});
        chk("beq_rs1", {123'd0, out_rs1}, 128'd11);
        chk("beq_rs2", {123'd0, out_rs2}, 128'd12);
        chk("beq_count1", {96'd0, out_count}, 128'd1);
        offer(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("beq_count2", {96'd0, out_count}, 128'd2);

        // Opcode sweep, illegal 0x7F last
        sweep = '{32'h000000B7, 32'h00000117, 32'h0000016F, 32'h000081E7, 32'h00012203,
                  32'h00110293, 32'h00208463, 32'h00112223, 32'h002081B3, 32'h0000007F};
        foreach (sweep[i]) offer(1'b1, sweep[i], 1'b1, 1'b0, acc);
        chk("illegal_flag", {127'd0, out_illegal}, 128'd1);
        chk("illegal_valid", {127'd0, out_valid}, 128'd1);
        offer(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Stall with A,B,C offered for 5 cycles
        do_reset();
        pend = '{32'h00100093, 32'h00200113, 32'h00300193};
        repeat (5) begin
            offer(1'b1, pend[0], 1'b0, 1'b0, acc);
            if (acc) void'(pend.pop_front());
        end
        chk("stall_held", {96'd0, 32'(3 - pend.size())}, {96'd0, 32'(DEPTH)});
        chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
        repeat (8) begin
            if (pend.size() != 0) begin
                offer(1'b1, pend[0], 1'b1, 1'b0, acc);
                if (acc) void'(pend.pop_front());
            end else offer(1'b0, 32'h0, 1'b1, 1'b0, acc);
        end
        chk("stall_count", {96'd0, out_count}, 128'd3);

        // Flush with everything full and a new offer
        do_reset();
        offer(1'b1, 32'h00400213, 1'b0, 1'b0, acc);
        offer(1'b1, 32'h00500293, 1'b0, 1'b0, acc);
        offer(1'b1, 32'h00600313, 1'b0, 1'b1, acc);
        chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
        chk("flush_count", {96'd0, out_count}, 128'd0);
        offer(1'b1, 32'h00700393, 1'b0, 1'b0, acc);
        offer(1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("flush_xfer_count", {96'd0, out_count}, 128'd1);
        chk("flush_xfer_valid", {127'd0, out_valid}, 128'd0);

        // Reset mid-stall, then one instruction with 1-cycle latency
        offer(1'b1, 32'h00800413, 1'b0, 1'b0, acc);
        offer(1'b1, 32'h00900493, 1'b0, 1'b0, acc);
        in_valid = 1'b1;
        do_reset();
        offer(1'b1, 32'h00A00513, 1'b0, 1'b0, acc);
        chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
        chk("post_rst_rd", {123'd0, out_rd}, 128'd10);
        offer(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else offer($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6,
                       $urandom_range(0, 99) < 3, acc);
        end

        // Drain
        repeat (4) offer(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("drain_empty", {127'd0, out_valid}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage between fetch and the immediate decoder / execute path. Accepts fetched instructions over a valid/ready handshake and classifies the opcode. It presents the raw immediate field plus the matching immediate-format control code, so the downstream immediate decoder can sign-extend combinationally. It also extracts register indices, flags illegal opcodes, supports pipeline flush and counts delivered instructions.

## Interface
Parameters:
- None; widths come from `XLEN`, `MAX_IMM_LEN` (= 32 − `OPCODE_LEN`) and `OPCODE_LEN` in constants.sv.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  `XLEN`  PC of in_instr.
- flush  in  1  discard everything held and anything offered this cycle.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  consumer accepts.
- out_pc  out  `XLEN`  registered PC.
- out_imm  out  `MAX_IMM_LEN`  instr[31:`OPCODE_LEN`], the immediate decoder's input.
- out_imm_ctrl  out  3  `I_TYPE`/`S_TYPE`/`B_TYPE`/`U_TYPE`/`J_TYPE` code.
- out_has_imm  out  1  0 for R-type (OP); out_imm_ctrl is then don't-care and driven `I_TYPE`.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_funct3  out  3  instr[14:12].
- out_illegal  out  1  opcode not recognised.
- out_count  out  32  delivered-instruction counter.

## Operation
- Opcode map (instr[6:0]):
  - 0110111 LUI and 0010111 AUIPC → U.
  - 1101111 JAL → J.
  - 1100111 JALR, 0000011 LOAD and 0010011 OP-IMM → I.
  - 1100011 BRANCH → B.
  - 0100011 STORE → S.
  - 0110011 OP → has_imm=0.
  - Anything else → out_illegal=1, has_imm=0, ctrl `I_TYPE`.
- Decode is done on the input side. The registers hold decoded fields, not the raw word, except out_imm.
- Transfer in: in_valid && in_ready && !flush. Transfer out: out_valid && out_ready.
- Illegal instructions are forwarded normally with out_illegal=1. They are never dropped.
- flush=1: all held entries are invalidated at the next edge, and any input offered that cycle is dropped. Flush has priority over simultaneous in/out transfers. A simultaneous output transfer still counts as delivered.
- out_count increments by 1 on every output transfer and wraps 0xFFFF_FFFF→0. It is not cleared by flush.
- Output payload is stable while out_valid && !out_ready (no flush).

## Timing
- Reset (rst_n low at an edge):
  - out_valid=0, out_count=0, and all payload registers are 0.
  - out_imm_ctrl resets to `I_TYPE`.
  - in_ready is forced to 0 combinationally while rst_n=0.
- Latency: 1 cycle. An instruction accepted at edge N is visible with out_valid=1 after edge N.
- Throughput: 1 instruction per cycle while out_ready=1.
- Back-to-back: with out_ready held 1, consecutive input transfers appear on consecutive cycles in order.
- Reset mid-stream: held instructions are lost and the counter clears. The first transfer after rst_n rises behaves as from empty.

## Configuration
- `DECODE_SKID_EN` defined:
  - Adds a second (skid) entry, and in_ready is driven from a register: in_ready = !skid_valid.
  - in_ready has no combinational path from out_ready.
  - When out_valid && !out_ready, one more instruction is accepted into the skid entry, then in_ready drops.
  - The skid entry moves to the output on the next output transfer, preserving order.
- `DECODE_SKID_EN` undefined:
  - Single entry, with in_ready = rst_n && (!out_valid || out_ready), which is combinational.
  - No instruction is accepted while stalled.
- Latency, throughput, flush and reset behaviour are identical in both builds.

## Test plan
- Reset then single transfers:
  - 0x123450B7 (LUI) → out_imm_ctrl=`U_TYPE`, has_imm=1, rd=1, out_imm=0x123450B7>>7.
  - 0x00C58663 (BEQ) → `B_TYPE`, rs1=11, rs2=12, out_count=1 then 2.
- Full opcode sweep: one legal instruction per opcode class plus 0x0000007F → correct ctrl/has_imm. 0x7F gives out_illegal=1 and is still delivered.
- Stall: out_ready=0 for 5 cycles while in_valid=1 with instructions A,B,C.
  - Without skid: only A is held and in_ready=0.
  - With skid: A and B are held and in_ready drops after B.
  - Release delivers A,B,C in order with out_count=3.
- Flush with out_valid=1, skid full and in_valid=1 in the same cycle → next cycle out_valid=0 and in_ready=1. Nothing from before the flush is delivered, and out_count is unchanged unless an output transfer coincided.
- Reset mid-stall (rst_n=0 one cycle) → out_valid=0, out_count=0, in_ready=0 during reset and 1 the cycle after. A subsequent instruction appears 1 cycle after acceptance.
- Counter wrap: run 2^32 deliveries (or force the counter to 0xFFFFFFFF) and deliver one → out_count=0.
